// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch slice.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical RV32I NOP encoding (addi x0, x0, 0)
//   fetch_entry_t : one fetch-buffer entry, instruction word plus its address
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage : riscv_pkg

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// In-order fetch buffer holding fetch_entry_t words, first-word fall-through.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, empties the buffer
//   flush     : empties the buffer (redirect); wins over push and pop
//   push      : write push_data at the tail (caller guarantees not full)
//   push_data : entry to write
//   pop       : retire the head entry (caller guarantees not empty)
//   head      : current head entry, meaningful only while count != 0
//   count     : number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // NOTE: the storage array has no reset; entries are only ever read
   // while count says they are valid, so clearing them would buy nothing.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: every register here is assigned with <= so all of them sample
   // the pre-edge values; a blocking = would let later lines see new values.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule : fetch_fifo

// File: rtl/riscv_fetch.sv
// ---------------------------------------------------------------------------
// riscv_fetch
// Instruction fetch stage: PC generation, credit-based request issue to a
// one-cycle-latency instruction memory, and a small in-order fetch buffer
// feeding decode with a valid/ready handshake. Redirects flush everything.
//   clk, reset             : clock; synchronous active-high reset
//   pc_init                : PC loaded while reset is high
//   redirect_e/redirect_pc : one-cycle redirect pulse and its target
//   imem_req/imem_addr     : memory read request and address
//   imem_rdata             : read data, valid the cycle after a request
//   if_valid/if_ready      : head-of-buffer handshake with decode
//   if_instr/if_pc         : head instruction and its address
//   fetch_cnt              : completed-transfer counter, present only when
//                            the FETCH_STATS_EN macro is defined
// ---------------------------------------------------------------------------
module riscv_fetch
   import riscv_pkg::*;
#(
   parameter int          BUF_DEPTH = 2,
   parameter int unsigned PC_STEP   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_init,
   input  logic            redirect_e,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     fetch_cnt
`endif
);

   localparam int              CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam logic [XLEN-1:0] PC_INC = XLEN'(PC_STEP);

   logic [XLEN-1:0] pc;
   logic            inflight;
   logic [XLEN-1:0] inflight_pc;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]  occupancy;
   logic            push;
   logic            pop;
   fetch_entry_t    push_entry;
   fetch_entry_t    head;

   // NOTE: each output of this block gets a value on every path (defaults
   // first), otherwise synthesis would infer latches to hold old values.
   always_comb begin
      if_valid   = 1'b0;
      if_instr   = '0;
      if_pc      = '0;
      imem_req   = 1'b0;
      push       = 1'b0;
      push_entry = '{pc: inflight_pc, instr: imem_rdata};

      if_valid = !reset && (count != '0);
      if (if_valid) begin
         if_instr = head.instr;
         if_pc    = head.pc;
      end
      pop = if_valid && if_ready;

      // Slots already owed: buffered entries plus the response in flight,
      // less the one leaving this cycle. One extra bit keeps the sum exact.
      occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
      imem_req  = !reset && !redirect_e && (occupancy < (CNT_W+1)'(BUF_DEPTH));

      // A response arriving during a redirect belongs to the old path.
      push = inflight && !redirect_e && !reset;
   end

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= pc_init;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (redirect_e) begin
            pc <= redirect_pc;
         end else if (imem_req) begin
            pc <= pc + PC_INC;
         end
      end
   end

   // Qualified by inflight, so it needs no reset.
   always_ff @(posedge clk) begin
      if (imem_req) begin
         inflight_pc <= pc;
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_e),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

`ifdef FETCH_STATS_EN
   // pop is already low during reset and never covers flushed entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= '0;
      end else if (pop) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule : riscv_fetch

// File: tb/tb_riscv_fetch.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch
// Directed bench for riscv_fetch. The instruction memory answers every
// request with addr + 0x100 one cycle later. Expected transfer addresses are
// queued per scenario; every observed transfer pops and compares the head.
// ---------------------------------------------------------------------------
module tb_riscv_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] pc_init;
   logic        redirect_e;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt;
`endif

   int          checks = 0;
   int          errors = 0;
   int          n_req  = 0;
   int          req_base;
   logic        last_req  = 1'b0;
   logic [31:0] last_addr = '0;
   logic [31:0] exp_pc;
   logic [31:0] exp_q[$];

   riscv_fetch #(
      .BUF_DEPTH (2),
      .PC_STEP   (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_init     (pc_init),
      .redirect_e  (redirect_e),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc)
`ifdef FETCH_STATS_EN
      ,
      .fetch_cnt   (fetch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sample just before the next rising edge; record requests and score
   // any transfer against the expected queue.
   task automatic settle();
      @(negedge clk);
      last_req  = imem_req;
      last_addr = imem_addr;
      if (imem_req) n_req++;
      if (if_valid && if_ready) begin
         check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_pc = exp_q.pop_front();
            check("xfer_pc", if_pc, exp_pc);
            check("xfer_instr", if_instr, exp_pc + 32'h100);
         end
      end
   endtask

   // One clock cycle: memory response for last cycle's request, new inputs.
   task automatic step(input logic rst, input logic rdy, input logic redir,
                       input logic [31:0] rpc);
      @(posedge clk);
      #1;
      imem_rdata  = last_req ? last_addr + 32'h100 : 32'hDEAD_BEEF;
      reset       = rst;
      if_ready    = rdy;
      redirect_e  = redir;
      redirect_pc = rpc;
      settle();
   endtask

   initial begin
      reset       = 1'b1;
      pc_init     = 32'h0;
      redirect_e  = 1'b0;
      redirect_pc = 32'h0;
      if_ready    = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;

      // ---- streaming from pc_init = 0 with decode always ready ----
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      check("rst_if_valid", 32'(if_valid), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, 32'h0);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 0);
         if (i == 0) begin
            check("t1_first_req", 32'(imem_req), 32'd1);
            check("t1_first_addr", imem_addr, 32'h0);
         end
         check("t1_if_valid", 32'(if_valid), (i >= 2) ? 32'd1 : 32'd0);
      end
      check("t1_drain", 32'(exp_q.size()), 32'd0);

      // ---- decode stalled: buffer fills, requests stop, head holds ----
      step(1, 0, 0, 0);
      req_base = n_req;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 0);
         if (i >= 2) begin
            check("t2_hold_valid", 32'(if_valid), 32'd1);
            check("t2_hold_pc", if_pc, 32'h0);
         end
      end
      check("t2_req_count", 32'(n_req - req_base), 32'd2);
      check("t2_full_no_req", 32'(imem_req), 32'd0);
      check("t2_hold_instr", if_instr, 32'h100);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("t2_release_valid", 32'(if_valid), 32'd1);
      end
      check("t2_drain", 32'(exp_q.size()), 32'd0);

      // ---- redirect with a transfer and a response in flight ----
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h44);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      check("t3_addr0", imem_addr, 32'h0);
      step(0, 1, 0, 0);
      check("t3_addr1", imem_addr, 32'h4);
      step(0, 1, 1, 32'h40);
      check("t3_redir_no_req", 32'(imem_req), 32'd0);
      check("t3_redir_head", if_pc, 32'h0);
      step(0, 1, 0, 0);
      check("t3_flushed", 32'(if_valid), 32'd0);
      check("t3_target_req", 32'(imem_req), 32'd1);
      check("t3_target_addr", imem_addr, 32'h40);
      step(0, 1, 0, 0);
      check("t3_stale_dropped", 32'(if_valid), 32'd0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("t3_drain", 32'(exp_q.size()), 32'd0);

      // ---- back-to-back redirects: only the last target survives ----
      exp_q.push_back(32'hC0);
      exp_q.push_back(32'hC4);
      step(0, 0, 1, 32'h80);
      check("t4_redir1_no_req", 32'(imem_req), 32'd0);
      step(0, 0, 1, 32'hC0);
      check("t4_redir2_no_req", 32'(imem_req), 32'd0);
      check("t4_flushed", 32'(if_valid), 32'd0);
      step(0, 1, 0, 0);
      check("t4_target_addr", imem_addr, 32'hC0);
      check("t4_empty0", 32'(if_valid), 32'd0);
      step(0, 1, 0, 0);
      check("t4_empty1", 32'(if_valid), 32'd0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("t4_drain", 32'(exp_q.size()), 32'd0);

      // ---- PC wrap across 2^32 ----
      pc_init = 32'hFFFF_FFF8;
      exp_q.push_back(32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0000_0004);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      check("t5_addr0", imem_addr, 32'hFFFF_FFF8);
      step(0, 1, 0, 0);
      check("t5_addr1", imem_addr, 32'hFFFF_FFFC);
      step(0, 1, 0, 0);
      check("t5_addr_wrap", imem_addr, 32'h0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("t5_drain", 32'(exp_q.size()), 32'd0);

      // ---- reset with two entries buffered ----
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("t6_full_valid", 32'(if_valid), 32'd1);
      check("t6_full_no_req", 32'(imem_req), 32'd0);
      check("t6_full_head", if_pc, 32'h8);
      pc_init = 32'h200;
      step(1, 1, 0, 0);
      check("t6_rst_valid", 32'(if_valid), 32'd0);
      check("t6_rst_req", 32'(imem_req), 32'd0);
      check("t6_rst_pc", if_pc, 32'h0);
      check("t6_rst_instr", if_instr, 32'h0);
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      step(0, 1, 0, 0);
      check("t6_first_req", 32'(imem_req), 32'd1);
      check("t6_first_addr", imem_addr, 32'h200);
`ifdef FETCH_STATS_EN
      check("t6_cnt_cleared", fetch_cnt, 32'd0);
`endif
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
`ifdef FETCH_STATS_EN
      check("t6_cnt_one", fetch_cnt, 32'd1);
`endif
      check("t6_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_riscv_fetch

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter: BUF_DEPTH, 2, fetch buffer entries (legal 2..8).
REQ-002 Parameter: PC_STEP, 4, bytes added to PC per sequential fetch.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_init  input  32  PC loaded while reset is high.
REQ-006 redirect_e  input  1  branch/jump redirect from execute, one-cycle pulse.
REQ-007 redirect_pc  input  32  redirect target, valid with redirect_e.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  read address, valid with imem_req.
REQ-010 imem_rdata  input  32  read data, valid exactly one cycle after the accepted request.
REQ-011 if_valid  output  1  buffer head holds an instruction for decode.
REQ-012 if_ready  input  1  decode accepts head; a transfer occurs when if_valid and if_ready are both high.
REQ-013 if_instr  output  32  head instruction word.
REQ-014 if_pc  output  32  address of if_instr.

Function
REQ-015 PC register: sequential fetch advances PC by PC_STEP per issued request, wrapping modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-016 Issue rule: imem_req = !reset && !redirect_e && (count + inflight - pop) < BUF_DEPTH; imem_addr = PC.
REQ-017 inflight is a 1-bit register set on an issued request and cleared the following cycle; the response is written into the buffer together with its request PC.
REQ-018 The buffer is an in-order FIFO; if_valid = (count != 0); if_instr and if_pc come straight from the head entry.
REQ-019 Latency: request at cycle N yields if_valid at N+2; with if_ready held high, throughput is one instruction per cycle.
REQ-020 Full buffer: no request issues; head and PC hold until a transfer frees credit; no entry is ever overwritten or dropped.
REQ-021 Empty buffer with if_ready high: no transfer; if_ready is ignored.
REQ-022 Simultaneous push and pop: count unchanged, ordering preserved.
REQ-023 Redirect cycle: the buffer is flushed, any in-flight response is discarded on arrival, PC <= redirect_pc, imem_req = 0; the target is requested the next cycle.
REQ-024 Redirect coinciding with a transfer: that transfer completes, then the flush applies.
REQ-025 Back-to-back redirects: the last one wins; every earlier target and in-flight response is discarded.
REQ-026 if_instr and if_pc hold stable while if_valid is high and if_ready is low.

Reset
REQ-027 While reset is high: PC <= pc_init, count = 0, inflight = 0, imem_req = 0, if_valid = 0; if_instr and if_pc read 0.
REQ-028 Reset mid-operation: all buffered and in-flight data is discarded; the first request after deassertion uses pc_init.
REQ-029 Reset has priority over redirect_e.

Configuration
REQ-030 Macro FETCH_STATS_EN: when defined, adds output fetch_cnt (32 bits), which counts completed transfers, wraps, is cleared by reset, and is not incremented by flushed entries; when undefined, the port and counter do not exist and behaviour is otherwise identical.

Structure
REQ-031 Shared package riscv_pkg: XLEN = 32, NOP_INSTR = 32'h00000013, and packed struct fetch_entry_t {pc, instr}.
REQ-032 One sub-module, fetch_fifo (parameterised depth, push/pop/flush, count output), instanced once.

Verification
REQ-033 pc_init = 0x0, imem returns addr+0x100, if_ready = 1 -> if_pc = 0, 4, 8, ... on consecutive cycles, first valid 2 cycles after the first request.
REQ-034 if_ready held low 5 cycles -> exactly 2 requests issue, buffer full, imem_req = 0, head stays pc = 0; on release, order 0, 4, 8 with no gaps or duplicates.
REQ-035 redirect_e with redirect_pc = 0x40 while a request is in flight -> if_valid = 0 next cycle, stale data never appears, next if_pc = 0x40.
REQ-036 Redirects to 0x80 then 0xC0 on consecutive cycles -> only 0xC0 is fetched; 0x80 is never presented.
REQ-037 pc_init = 0xFFFFFFF8 -> if_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 reset asserted for 1 cycle with 2 entries buffered -> if_valid = 0 and imem_req = 0 during reset; the first request after reset is to pc_init; with FETCH_STATS_EN, fetch_cnt = 0.
